// File: rtl/pipe_hazard_ctrl.sv
// Post-decode scoreboard for the in-order pipeline: load-use stall, operand
// bypass selection, squash handling, W-stage write controls and event counters.
module pipe_hazard_ctrl #(
    parameter int S        = 3,
    parameter int AW       = 5,
    parameter int LD_STAGE = 2,
    parameter int CNT_W    = 16,
    localparam int SW      = $clog2(S + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_val,
    input  logic             d_rs1_en,
    input  logic [AW-1:0]    d_rs1,
    input  logic             d_rs2_en,
    input  logic [AW-1:0]    d_rs2,
    input  logic             d_wen,
    input  logic [AW-1:0]    d_waddr,
    input  logic             d_is_load,
    input  logic             squash_D,
    output logic             stall_D,
    output logic             reg_en_F,
    output logic             reg_en_D,
    output logic [SW-1:0]    byp_sel1,
    output logic [SW-1:0]    byp_sel2,
    output logic [S-1:0]     val_vec,
    output logic             rf_wen_W,
    output logic [AW-1:0]    rf_waddr_W,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [S-1:0]  val_q;
    logic [S-1:0]  wen_q;
    logic [S-1:0]  ld_q;
    logic [AW-1:0] waddr_q [S];
    logic          haz1;
    logic          haz2;
    logic          accept_d;

    // Walk oldest to youngest so the youngest matching stage wins, even when
    // an older match would already be bypassable.
    always_comb begin
        byp_sel1 = '0;
        byp_sel2 = '0;
        haz1     = 1'b0;
        haz2     = 1'b0;
        for (int k = S; k >= 1; k--) begin
            if (val_q[k-1] && wen_q[k-1] && (waddr_q[k-1] == d_rs1)) begin
                byp_sel1 = SW'(k);
                haz1     = ld_q[k-1] && (k < LD_STAGE);
            end
            if (val_q[k-1] && wen_q[k-1] && (waddr_q[k-1] == d_rs2)) begin
                byp_sel2 = SW'(k);
                haz2     = ld_q[k-1] && (k < LD_STAGE);
            end
        end
        if (!d_val || !d_rs1_en || (d_rs1 == '0)) begin
            byp_sel1 = '0;
            haz1     = 1'b0;
        end
        if (!d_val || !d_rs2_en || (d_rs2 == '0)) begin
            byp_sel2 = '0;
            haz2     = 1'b0;
        end
    end

    assign stall_D    = d_val && !squash_D && (haz1 || haz2);
    assign reg_en_F   = !stall_D;
    assign reg_en_D   = !stall_D;
    assign accept_d   = d_val && !stall_D && !squash_D;
    assign val_vec    = val_q;
    assign rf_wen_W   = val_q[S-1] && wen_q[S-1];
    assign rf_waddr_W = waddr_q[S-1];

    // Stage 1 takes the D instruction or a bubble; the address of a bubble is
    // never looked at, so it simply follows d_waddr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q      <= '0;
            wen_q      <= '0;
            ld_q       <= '0;
            for (int k = 0; k < S; k++) begin
                waddr_q[k] <= '0;
            end
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            val_q <= {val_q[S-2:0], accept_d};
            wen_q <= {wen_q[S-2:0], accept_d && d_wen};
            ld_q  <= {ld_q[S-2:0], accept_d && d_is_load};
            for (int k = S - 1; k >= 1; k--) begin
                waddr_q[k] <= waddr_q[k-1];
            end
            waddr_q[0] <= d_waddr;
            if (stall_D && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (squash_D && d_val && (squash_cnt != '1)) begin
                squash_cnt <= squash_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and control-tracking unit for the in-order pipeline. It replaces the fixed-depth valid and instruction-register chain with a configurable post-decode scoreboard of S stages (stage 1 = X … stage S = W). It produces the D-stage stall, operand bypass selects, squash handling and the W-stage register-file write controls. It also keeps saturating stall and squash event counters for performance monitoring.

Parameters:
S, 3, number of post-decode stages tracked (X..W); legal range 2..7
AW, 5, register address width
LD_STAGE, 2, first stage index at which load data is bypassable; legal range 1..S
CNT_W, 16, width of the performance counters
(Derived: SW = $clog2(S+1), the width of each bypass select.)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
d_val  in  1  D holds a valid instruction
d_rs1_en  in  1  instruction reads rs1
d_rs1  in  AW  rs1 address
d_rs2_en  in  1  instruction reads rs2
d_rs2  in  AW  rs2 address
d_wen  in  1  instruction writes rd
d_waddr  in  AW  rd address
d_is_load  in  1  result produced late (at LD_STAGE)
squash_D  in  1  branch/jump resolved taken; kill the instruction in D this cycle
stall_D  out  1  hold F and D, inject a bubble into X
reg_en_F  out  1  equals ~stall_D
reg_en_D  out  1  equals ~stall_D
byp_sel1  out  SW  rs1 source: 0 = register file, k = stage k result
byp_sel2  out  SW  rs2 source, same encoding
val_vec  out  S  bit k-1 = stage k holds a valid instruction
rf_wen_W  out  1  val and wen of stage S
rf_waddr_W  out  AW  waddr of stage S
stall_cnt  out  CNT_W  cycles with stall_D=1, saturating
squash_cnt  out  CNT_W  cycles with squash_D=1 and d_val=1, saturating

Behaviour:
- State per stage k: val, wen, is_load, waddr. The remaining state is the two counters.
- Reset (rst=0, asynchronous): all val, wen and is_load bits = 0; both counters = 0. Consequently val_vec=0, rf_wen_W=0 and stall_D=0. waddr resets to 0.
- Each cycle the entries shift: stage k+1 takes stage k. Stage S drains into the register-file write.
- Stage 1 load value:
  - bubble (val=0, wen=0) if d_val=0, stall_D=1 or squash_D=1;
  - otherwise {1, d_wen, d_is_load, d_waddr}.
- Match rule, for an operand with en=1 and addr≠0: find the smallest k (youngest) with val, wen and waddr==addr.
  - No match → sel=0.
  - Match with is_load=1 and k<LD_STAGE → load-use hazard.
  - Otherwise sel=k.
  - Operands with en=0 or addr=0 always give sel=0 and never hazard.
- Only the youngest match counts. An older match is ignored even if it is ready.
- stall_D = d_val & ~squash_D & (hazard on rs1 | hazard on rs2).
- squash_D has priority over stall: D is killed, stall_D=0, and F/D advance.
- When stall_D=1, byp_sel values are don't-care and are not checked. Otherwise they are combinational from current state and D inputs, with zero latency.
- The stall persists until the load reaches LD_STAGE, i.e. LD_STAGE-k cycles.
- rf_wen_W and rf_waddr_W are combinational from stage S, with no extra latency.
- Counters:
  - increment by 1 per qualifying cycle;
  - hold at 2^CNT_W-1 (no wrap);
  - a stall and a squash cannot occur in the same cycle, by the priority rule.
- Reset mid-stall: all state clears, and the next cycle has stall_D=0 regardless of D inputs, because the scoreboard is empty.
- d_val=0 ignores all other D inputs: no stall, sel=0.

Test Plan:
1. Reset, then back-to-back writes to x5 in D: in cycle 1, rs1=x5, wen x5 → byp_sel1=1; one cycle later with no new writer → byp_sel1=2; at S → 3; one cycle after that → 0; rf_wen_W=1 with rf_waddr_W=5 at cycle +3.
2. Load x7, followed immediately by a reader of x7 (LD_STAGE=2): stall_D=1 and reg_en_F=reg_en_D=0 for exactly 1 cycle, val_vec shows the bubble (bit0=0), then byp_sel2=2; stall_cnt=1.
3. The same load-use case with squash_D=1 in the stall cycle → stall_D=0, stage 1 gets a bubble, squash_cnt=1, stall_cnt=0.
4. Stages 1 and 2 both write x3, reader of x3 → byp_sel1=1. Reader of x0 with stages writing x0 → sel=0, no stall.
5. CNT_W=2, six consecutive load-use stalls (load each time) → stall_cnt reaches 3 and holds at 3.
6. Assert rst low asynchronously mid-stall (between clock edges) → val_vec=0, stall_D=0 and counters=0 immediately. After release, a reader with no in-flight writer → sel=0.
